// File: rtl/muldiv_ctrl.sv
// HI/LO owner and multi-cycle MULT/MULTU/DIV/DIVU sequencer for the execute stage.
// Multiplies wait out a fixed latency; divides run a radix-2 restoring loop plus one sign-fix edge.
module muldiv_ctrl #(
    parameter int MUL_LATENCY = 4,
    parameter int DIV_ITERS   = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        rd_req,
    input  logic        rd_sel,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    localparam logic [4:0] MUL_CNT0 = 5'(MUL_LATENCY - 1);
    localparam logic [4:0] DIV_CNT0 = 5'(DIV_ITERS - 1);

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [63:0] r_prod;
    logic [31:0] r_rem;
    logic [31:0] r_dvd;
    logic [31:0] r_dvsr;
    logic [31:0] r_q;
    logic [31:0] r_rs_raw;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;

    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [31:0] w_abs_rs;
    logic [31:0] w_abs_rt;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic [32:0] w_rem_sh;
    logic        w_ge;
    logic [31:0] w_diff;

    // Sign flags only matter for the signed ops (op[0]=0).
    assign w_rs_neg = ~op[0] & rs_data[31];
    assign w_rt_neg = ~op[0] & rt_data[31];
    assign w_abs_rs = w_rs_neg ? neg32(rs_data) : rs_data;
    assign w_abs_rt = w_rt_neg ? neg32(rt_data) : rt_data;

    assign w_ext_a  = op[0] ? {32'b0, rs_data} : {{32{rs_data[31]}}, rs_data};
    assign w_ext_b  = op[0] ? {32'b0, rt_data} : {{32{rt_data[31]}}, rt_data};
    assign w_prod   = w_ext_a * w_ext_b;

    // When the trial subtraction succeeds the difference always fits in 32 bits.
    assign w_rem_sh = {r_rem, r_dvd[31]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_dvsr});
    assign w_diff   = w_rem_sh[31:0] - r_dvsr;

    assign stall    = busy & (start | rd_req | wr_en);
    assign rd_data  = rd_sel ? hi : lo;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        r_rs_raw <= rs_data;
                        r_dz     <= (rt_data == 32'd0);
                        if (!op[1]) begin
                            r_state <= S_MUL;
                            r_cnt   <= MUL_CNT0;
                            r_prod  <= w_prod;
                        end else begin
                            r_state <= S_DIV;
                            r_cnt   <= DIV_CNT0;
                            r_rem   <= 32'd0;
                            r_q     <= 32'd0;
                            r_dvd   <= w_abs_rs;
                            r_dvsr  <= w_abs_rt;
                            r_neg_q <= w_rs_neg ^ w_rt_neg;
                            r_neg_r <= w_rs_neg;
                        end
                    end else if (wr_en) begin
                        if (rd_sel) hi <= wr_data;
                        else        lo <= wr_data;
                    end
                end
                S_MUL: begin
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd0) begin
                        {hi, lo} <= r_prod;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                S_DIV: begin
                    r_rem <= w_ge ? w_diff : w_rem_sh[31:0];
                    r_q   <= {r_q[30:0], w_ge};
                    r_dvd <= {r_dvd[30:0], 1'b0};
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd0) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_dz) begin
                        lo <= 32'hFFFF_FFFF;
                        hi <= r_rs_raw;
                    end else begin
                        lo <= r_neg_q ? neg32(r_q)   : r_q;
                        hi <= r_neg_r ? neg32(r_rem) : r_rem;
                    end
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
